keycode_ram_writer: RTL and testbench
=====================================

# keycode_ram_writer

Front end between the PS/2 scancode byte stream and the keyboard RAM write port. It decodes the E0 (extended) and F0 (break) prefixes, packs each complete key event into one RAM word, and writes it into a circular buffer held in the RAM. It also publishes the head address and fill status so the consumer can read events from the RAM read port in arrival order.

## Interface
- DATA_WIDTH, 16, RAM word width; must be ≥ 10.
- ADDR_WIDTH, 8, RAM address width.
- MEM_SIZE, 8, highest RAM address used; buffer capacity is MEM_SIZE+1 entries (addresses 0..MEM_SIZE).

- Clock  in  1  single clock; all logic on posedge.
- Reset  in  1  synchronous, active-high.
- iScanValid  in  1  one-cycle strobe; iScanCode valid.
- iScanCode  in  8  received PS/2 byte.
- iAck  in  1  consumer has taken the head entry; pop one.
- iClear  in  1  synchronous flush of buffer, decoder and overflow flag.
- oWriteEnable  out  1  RAM write strobe.
- oWriteAddress  out  ADDR_WIDTH  RAM write address.
- oDataIn  out  DATA_WIDTH  RAM write data.
- oHeadAddress  out  ADDR_WIDTH  address of oldest unread entry.
- oCount  out  ADDR_WIDTH+1  entries committed.
- oEmpty  out  1  oCount == 0.
- oFull  out  1  oCount == MEM_SIZE+1.
- oOverflow  out  1  sticky: an event was dropped.

## Operation
- Entry format: bit 9 = extended, bit 8 = break, bits 7:0 = scancode; bits DATA_WIDTH-1:10 zero.
- Decoder FSM states: IDLE, EXT, BRK, EXT_BRK. Transitions apply only when iScanValid is high.
  - 8'hE0 in any state goes to EXT.
  - 8'hF0 goes from IDLE to BRK, from EXT to EXT_BRK, and from BRK or EXT_BRK to the same state.
  - Any other byte completes an event. Flags come from the current state (EXT gives ext=1, BRK gives brk=1, EXT_BRK gives both). Next state is IDLE.
- On a completed event: if the buffer is not full, or iAck pops a non-empty buffer in the same cycle, push it. Otherwise drop it and set oOverflow.
- Push: write pointer advances with wrap MEM_SIZE→0, and oCount increments.
- Pop (iAck && !oEmpty): head pointer advances with wrap MEM_SIZE→0, and oCount decrements. iAck while empty is ignored.
- Simultaneous push and pop: oCount is unchanged and both pointers advance.
- iClear has priority over iScanValid and iAck in the same cycle. It clears the pointers, oCount, FSM state (to IDLE) and oOverflow; any event completing in that cycle is discarded.
- Reset does everything iClear does.

## Timing
- Reset values: oWriteEnable 0, oWriteAddress 0, oDataIn 0, oHeadAddress 0, oCount 0, oEmpty 1, oFull 0, oOverflow 0, FSM IDLE.
- All outputs are registered.
- Event byte accepted in cycle t:
  - oWriteEnable=1 with the write address and data in cycle t+1.
  - oCount, oEmpty and oFull update in cycle t+1.
  - The RAM word is stored at the edge ending t+1.
- oWriteEnable is high for exactly one cycle per pushed event. It stays low for prefixes and dropped events.
- Consumer side:
  - Present oHeadAddress to the RAM read port as soon as oEmpty is low.
  - RAM read data is valid one cycle later; assert iAck after consuming it.
  - oHeadAddress updates the cycle after iAck.
- Back-to-back iScanValid on consecutive cycles is supported at one byte per cycle.

## Structure
- Shared package holds:
  - the prefix constants (PFX_EXT = 8'hE0, PFX_BRK = 8'hF0);
  - the FSM state encoding (2 bits);
  - entry bit positions (EXT_BIT = 9, BRK_BIT = 8).
- One sub-module is natural: mod_pointer, an ADDR_WIDTH counter with increment enable, synchronous clear and wrap at MEM_SIZE, instantiated for the write pointer and the head pointer.
- The writer connects to the RAM write port only; the consumer owns the read port.

## Test plan
- Reset, then bytes 1C → cycle after the 1C strobe: oWriteEnable=1, address 0, data 16'h001C; oCount 1; oEmpty 0.
- Bytes F0,1C → one write, data 16'h011C. Bytes E0,F0,75 → one write, data 16'h0375. No writes on prefix bytes.
- Nine events with MEM_SIZE=8 → addresses 0..8, oFull=1. A tenth event → no write, oOverflow=1, oCount stays 9.
- While full, a tenth event together with iAck → write to address 0 (wrap), oCount stays 9, oHeadAddress goes to 1, oOverflow stays 0.
- iClear in the same cycle as a 1C strobe and iAck → no write; oCount 0, oHeadAddress 0, oOverflow 0, FSM IDLE.
- Reset asserted after an E0 byte, then 1C → data 16'h001C (extended flag not carried over).

Source files
------------

// File: rtl/keycode_ram_writer_pkg.sv
// Shared constants and types for the PS/2 keycode event writer.
package keycode_ram_writer_pkg;

  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  localparam int unsigned EXT_BIT = 9;
  localparam int unsigned BRK_BIT = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } dec_state_e;

endpackage

// File: rtl/keycode_ram_writer_mod_pointer.sv
// Circular buffer pointer: counts 0..MEM_SIZE and wraps back to 0.
module mod_pointer #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned MEM_SIZE   = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iClear,
  input  logic                  iInc,
  output logic [ADDR_WIDTH-1:0] oPtr
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(MEM_SIZE);

  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (iClear)
      ptr_d = '0;
    else if (iInc)
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + ADDR_WIDTH'(1);
  end

  always_ff @(posedge Clock) begin
    if (Reset)
      ptr_q <= '0;
    else
      ptr_q <= ptr_d;
  end

  assign oPtr = ptr_q;

endmodule

// File: rtl/keycode_ram_writer.sv
// Decodes E0/F0 scancode prefixes and writes one packed event per key into a
// RAM-backed circular buffer, publishing head address and fill status.
module keycode_ram_writer
  import keycode_ram_writer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned MEM_SIZE   = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iScanValid,
  input  logic [7:0]            iScanCode,
  input  logic                  iAck,
  input  logic                  iClear,
  output logic                  oWriteEnable,
  output logic [ADDR_WIDTH-1:0] oWriteAddress,
  output logic [DATA_WIDTH-1:0] oDataIn,
  output logic [ADDR_WIDTH-1:0] oHeadAddress,
  output logic [ADDR_WIDTH:0]   oCount,
  output logic                  oEmpty,
  output logic                  oFull,
  output logic                  oOverflow
);

  localparam logic [ADDR_WIDTH:0] CAPACITY = (ADDR_WIDTH+1)'(MEM_SIZE + 1);

  dec_state_e            state_q, state_d;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  empty_q, full_q, ovf_q;

  logic                  ext_flag, brk_flag;
  logic                  scan_event, push, pop, drop;
  logic [DATA_WIDTH-1:0] entry_d;
  logic [ADDR_WIDTH-1:0] wr_ptr, head_ptr;

  always_comb begin
    state_d    = state_q;
    scan_event = 1'b0;
    ext_flag   = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
    brk_flag   = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);

    if (iScanValid) begin
      if (iScanCode == PFX_EXT) begin
        state_d = ST_EXT;
      end else if (iScanCode == PFX_BRK) begin
        case (state_q)
          ST_IDLE: state_d = ST_BRK;
          ST_EXT:  state_d = ST_EXT_BRK;
          default: state_d = state_q;
        endcase
      end else begin
        scan_event = 1'b1;
        state_d    = ST_IDLE;
      end
    end

    // A same-cycle pop frees the slot the incoming event needs when full.
    pop  = iAck && !empty_q;
    push = scan_event && (!full_q || pop);
    drop = scan_event && !push;

    if (iClear) begin
      state_d = ST_IDLE;
      pop     = 1'b0;
      push    = 1'b0;
      drop    = 1'b0;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase
    if (iClear)
      count_d = '0;

    entry_d          = '0;
    entry_d[7:0]     = iScanCode;
    entry_d[EXT_BIT] = ext_flag;
    entry_d[BRK_BIT] = brk_flag;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      waddr_q <= '0;
      data_q  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= push;
      if (push) begin
        waddr_q <= wr_ptr;
        data_q  <= entry_d;
      end
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == CAPACITY);
      ovf_q   <= iClear ? 1'b0 : (ovf_q | drop);
    end
  end

  mod_pointer #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .MEM_SIZE  (MEM_SIZE)
  ) u_wr_ptr (
    .Clock (Clock),
    .Reset (Reset),
    .iClear(iClear),
    .iInc  (push),
    .oPtr  (wr_ptr)
  );

  mod_pointer #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .MEM_SIZE  (MEM_SIZE)
  ) u_head_ptr (
    .Clock (Clock),
    .Reset (Reset),
    .iClear(iClear),
    .iInc  (pop),
    .oPtr  (head_ptr)
  );

  assign oWriteEnable  = we_q;
  assign oWriteAddress = waddr_q;
  assign oDataIn       = data_q;
  assign oHeadAddress  = head_ptr;
  assign oCount        = count_q;
  assign oEmpty        = empty_q;
  assign oFull         = full_q;
  assign oOverflow     = ovf_q;

endmodule

// File: tb/tb_keycode_ram_writer.sv
// Scoreboard bench for keycode_ram_writer: a queue-based buffer model predicts
// writes and status; a monitor compares them against the DUT every cycle.
module tb_keycode_ram_writer;

  localparam int DW  = 16;
  localparam int AW  = 8;
  localparam int MS  = 8;
  localparam int CAP = MS + 1;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          iScanValid = 1'b0;
  logic [7:0]    iScanCode = '0;
  logic          iAck = 1'b0;
  logic          iClear = 1'b0;
  logic          oWriteEnable;
  logic [AW-1:0] oWriteAddress;
  logic [DW-1:0] oDataIn;
  logic [AW-1:0] oHeadAddress;
  logic [AW:0]   oCount;
  logic          oEmpty, oFull, oOverflow;

  keycode_ram_writer #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .MEM_SIZE  (MS)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .iScanValid   (iScanValid),
    .iScanCode    (iScanCode),
    .iAck         (iAck),
    .iClear       (iClear),
    .oWriteEnable (oWriteEnable),
    .oWriteAddress(oWriteAddress),
    .oDataIn      (oDataIn),
    .oHeadAddress (oHeadAddress),
    .oCount       (oCount),
    .oEmpty       (oEmpty),
    .oFull        (oFull),
    .oOverflow    (oOverflow)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    bit we;
    int count;
    bit empty;
    bit full;
    bit ovf;
    int head;
    bit after_reset;
  } status_t;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  status_t st_q[$];
  wr_t     wr_q[$];

  int passed = 0;
  int total  = 0;

  // Reference model state: the buffer as a plain queue plus prefix flags.
  int fifo[$];
  int m_head = 0;
  int m_wr   = 0;
  bit m_ext  = 0;
  bit m_brk  = 0;
  bit m_ovf  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act === exp)
      passed++;
    else
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step(input bit rst, input bit v, input logic [7:0] code,
                      input bit ack, input bit clr);
    status_t s;
    bit      popped;
    int      entry;
    @(negedge Clock);
    Reset      = rst;
    iScanValid = v;
    iScanCode  = code;
    iAck       = ack;
    iClear     = clr;

    s.we          = 0;
    s.after_reset = rst;
    if (rst || clr) begin
      fifo.delete();
      m_head = 0;
      m_wr   = 0;
      m_ext  = 0;
      m_brk  = 0;
      m_ovf  = 0;
    end else begin
      popped = ack && (fifo.size() > 0);
      if (popped) begin
        void'(fifo.pop_front());
        m_head = (m_head + 1) % CAP;
      end
      if (v) begin
        if (code == 8'hE0) begin
          m_ext = 1;
          m_brk = 0;
        end else if (code == 8'hF0) begin
          m_brk = 1;
        end else begin
          entry = (int'(m_ext) * 512) + (int'(m_brk) * 256) + int'(code);
          m_ext = 0;
          m_brk = 0;
          if (fifo.size() < CAP) begin
            fifo.push_back(entry);
            wr_q.push_back('{addr: m_wr, data: entry});
            s.we = 1;
            m_wr = (m_wr + 1) % CAP;
          end else begin
            m_ovf = 1;
          end
        end
      end
    end
    s.count = fifo.size();
    s.empty = (fifo.size() == 0);
    s.full  = (fifo.size() == CAP);
    s.ovf   = m_ovf;
    s.head  = m_head;
    st_q.push_back(s);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0, 0);
  endtask

  // Monitor: outputs settle after the edge that consumed the previous drive.
  initial begin
    status_t s;
    wr_t     w;
    forever begin
      @(posedge Clock);
      #2;
      if (st_q.size() > 0) begin
        s = st_q.pop_front();
        check("write_enable", oWriteEnable, s.we);
        check("count", oCount, s.count);
        check("empty", oEmpty, s.empty);
        check("full", oFull, s.full);
        check("overflow", oOverflow, s.ovf);
        check("head_address", oHeadAddress, s.head);
        if (s.after_reset) begin
          check("reset_write_address", oWriteAddress, 0);
          check("reset_data", oDataIn, 0);
        end
        if (oWriteEnable === 1'b1) begin
          if (wr_q.size() == 0) begin
            check("unexpected_write", 1, 0);
          end else begin
            w = wr_q.pop_front();
            check("write_address", oWriteAddress, w.addr);
            check("write_data", oDataIn, w.data);
          end
        end
      end
    end
  end

  initial begin
    int ack_pct;
    int r;
    logic [7:0] code;

    step(1, 0, 8'h00, 0, 0);
    step(1, 0, 8'h00, 0, 0);
    idle(1);

    step(0, 1, 8'h1C, 0, 0);
    idle(1);
    step(0, 1, 8'hF0, 0, 0);
    step(0, 1, 8'h1C, 0, 0);
    step(0, 1, 8'hE0, 0, 0);
    step(0, 1, 8'hF0, 0, 0);
    step(0, 1, 8'h75, 0, 0);
    idle(1);

    // Fill, overflow, then full-with-pop wraparound.
    step(0, 0, 8'h00, 0, 1);
    for (int i = 0; i < CAP; i++) step(0, 1, 8'h10 + 8'(i), 0, 0);
    step(0, 1, 8'h2A, 0, 0);
    idle(2);
    step(0, 0, 8'h00, 0, 1);
    for (int i = 0; i < CAP; i++) step(0, 1, 8'h20 + 8'(i), 0, 0);
    step(0, 1, 8'h3B, 1, 0);
    idle(1);

    // Clear beats a completing event and an ack in the same cycle.
    step(0, 1, 8'h1C, 1, 1);
    idle(1);
    step(0, 1, 8'h1C, 0, 0);

    // Reset after a dangling E0 must not leak the extended flag.
    step(0, 1, 8'hE0, 0, 0);
    step(1, 0, 8'h00, 0, 0);
    step(0, 1, 8'h1C, 0, 0);
    idle(2);

    for (int phase = 0; phase < 16; phase++) begin
      ack_pct = (phase % 4) * 25;
      for (int i = 0; i < 150; i++) begin
        r = int'($urandom_range(0, 9));
        if (r < 2)      code = 8'hE0;
        else if (r < 4) code = 8'hF0;
        else            code = 8'($urandom_range(0, 255));
        step(($urandom_range(0, 999) < 3),
             ($urandom_range(0, 99) < 60),
             code,
             ($urandom_range(0, 99) < ack_pct),
             ($urandom_range(0, 999) < 8));
      end
    end

    idle(3);
    @(posedge Clock);
    #4;
    check("status_queue_drained", st_q.size(), 0);
    check("write_queue_drained", wr_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
